// File: rtl/ras.sv
// ----------------------------------------------------------------------------
// ras -- return address stack for the fetch predictor complex.
//
// A circular buffer of halfword-aligned return targets (PC[31:1]). A call
// pushes its link address and a return pops it. The pointer and the count are
// exported so the checkpoint array can save them and write them back after a
// mispredict or flush.
//
// Ports:
//   CLK            clock, all state updates on the rising edge
//   RST            asynchronous active-high reset
//   push_valid     call predicted this cycle, push push_target
//   push_target    link address PC[31:1]
//   pop_valid      return predicted this cycle, pop the top entry
//   restore_valid  load ptr/count from restore_index/restore_count
//   restore_index  pointer value to restore
//   restore_count  count value to restore (0..RAS_ENTRIES)
//   ret_target     current top entry, entry[ptr]
//   ras_empty      count == 0
//   ras_index      current pointer (checkpoint save)
//   ras_count      current valid count (checkpoint save)
// ----------------------------------------------------------------------------
module ras #(
  parameter int RAS_ENTRIES      = 8,
  parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  input  logic                        restore_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
  input  logic [RAS_INDEX_WIDTH:0]    restore_count,
  output logic [RAS_TARGET_WIDTH-1:0] ret_target,
  output logic                        ras_empty,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_INDEX_WIDTH:0]    ras_count
);

  localparam logic [RAS_INDEX_WIDTH:0]   FULL_COUNT = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);
  localparam logic [RAS_INDEX_WIDTH:0]   CNT_ZERO   = (RAS_INDEX_WIDTH+1)'(0);
  localparam logic [RAS_INDEX_WIDTH:0]   CNT_ONE    = (RAS_INDEX_WIDTH+1)'(1);
  localparam logic [RAS_INDEX_WIDTH-1:0] PTR_ONE    = RAS_INDEX_WIDTH'(1);

  logic [RAS_TARGET_WIDTH-1:0] entry_r [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  ptr_r;
  logic [RAS_INDEX_WIDTH:0]    count_r;

  logic [RAS_INDEX_WIDTH-1:0]  ptr_inc_s;
  logic [RAS_INDEX_WIDTH-1:0]  ptr_dec_s;
  logic [RAS_INDEX_WIDTH-1:0]  ptr_nxt_s;
  logic [RAS_INDEX_WIDTH:0]    count_nxt_s;
  logic                        wr_en_s;
  logic [RAS_INDEX_WIDTH-1:0]  wr_idx_s;

  // Pointer arithmetic wraps naturally in RAS_INDEX_WIDTH bits.
  assign ptr_inc_s = ptr_r + PTR_ONE;
  assign ptr_dec_s = ptr_r - PTR_ONE;

  // Next-state selection in priority order: restore, push+pop, push, pop, hold.
  always_comb begin
    ptr_nxt_s   = ptr_r;
    count_nxt_s = count_r;
    wr_en_s     = 1'b0;
    wr_idx_s    = ptr_r;
    if (restore_valid) begin
      ptr_nxt_s   = restore_index;
      // An out-of-range restore count is clamped so count never exceeds depth.
      count_nxt_s = (restore_count > FULL_COUNT) ? FULL_COUNT : restore_count;
    end else if (push_valid && pop_valid) begin
      // Call-return in one cycle replaces the top in place.
      wr_en_s     = 1'b1;
      wr_idx_s    = ptr_r;
      count_nxt_s = (count_r == CNT_ZERO) ? CNT_ONE : count_r;
    end else if (push_valid) begin
      // When full this overwrites the oldest entry (circular overwrite).
      wr_en_s     = 1'b1;
      wr_idx_s    = ptr_inc_s;
      ptr_nxt_s   = ptr_inc_s;
      count_nxt_s = (count_r == FULL_COUNT) ? FULL_COUNT : (count_r + CNT_ONE);
    end else if (pop_valid) begin
      // A pop on empty still moves the pointer; ras_empty flags low confidence.
      ptr_nxt_s   = ptr_dec_s;
      count_nxt_s = (count_r == CNT_ZERO) ? CNT_ZERO : (count_r - CNT_ONE);
    end else begin
      ptr_nxt_s   = ptr_r;
      count_nxt_s = count_r;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_r   <= '0;
      count_r <= '0;
    end else begin
      ptr_r   <= ptr_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; entries are never repaired on restore.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entry_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      entry_r[wr_idx_s] <= push_target;
    end else begin
      entry_r[wr_idx_s] <= entry_r[wr_idx_s];
    end
  end

  // Zero-cycle read straight from registered state.
  assign ret_target = entry_r[ptr_r];
  assign ras_empty  = (count_r == CNT_ZERO);
  assign ras_index  = ptr_r;
  assign ras_count  = count_r;

endmodule

// File: tb/tb_ras.sv
// ----------------------------------------------------------------------------
// tb_ras -- directed self-checking bench for ras.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_ras;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        push_valid = 1'b0;
  logic [30:0] push_target = 31'd0;
  logic        pop_valid = 1'b0;
  logic        restore_valid = 1'b0;
  logic [2:0]  restore_index = 3'd0;
  logic [3:0]  restore_count = 4'd0;
  logic [30:0] ret_target;
  logic        ras_empty;
  logic [2:0]  ras_index;
  logic [3:0]  ras_count;

  int n_checks = 0;
  int n_fail   = 0;

  ras dut (
    .CLK           (CLK),
    .RST           (RST),
    .push_valid    (push_valid),
    .push_target   (push_target),
    .pop_valid     (pop_valid),
    .restore_valid (restore_valid),
    .restore_index (restore_index),
    .restore_count (restore_count),
    .ret_target    (ret_target),
    .ras_empty     (ras_empty),
    .ras_index     (ras_index),
    .ras_count     (ras_count)
  );

  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check all four outputs at once.
  task automatic check_state(input string tag, input logic [30:0] t, input logic e,
                             input logic [2:0] idx, input logic [3:0] cnt);
    check_eq({tag, ".ret"},   {1'b0, ret_target}, {1'b0, t});
    check_eq({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, e});
    check_eq({tag, ".index"}, {29'd0, ras_index}, {29'd0, idx});
    check_eq({tag, ".count"}, {28'd0, ras_count}, {28'd0, cnt});
  endtask

  // Present one operation for one clock, then return inputs to idle.
  task automatic op(input logic pu, input logic po, input logic [30:0] tgt,
                    input logic rv, input logic [2:0] ri, input logic [3:0] rc);
    push_valid = pu; pop_valid = po; push_target = tgt;
    restore_valid = rv; restore_index = ri; restore_count = rc;
    @(posedge CLK); #1;
    push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
  endtask

  task automatic push(input logic [30:0] tgt);
    op(1'b1, 1'b0, tgt, 1'b0, 3'd0, 4'd0);
  endtask

  task automatic pop();
    op(1'b0, 1'b1, 31'd0, 1'b0, 3'd0, 4'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    do_reset();
    check_state("reset", 31'd0, 1'b1, 3'd0, 4'd0);

    // Basic LIFO
    push(31'h1000); push(31'h2000); push(31'h3000);
    check_state("push3", 31'h3000, 1'b0, 3'd3, 4'd3);
    pop();
    check_state("pop1", 31'h2000, 1'b0, 3'd2, 4'd2);
    pop();
    check_state("pop2", 31'h1000, 1'b0, 3'd1, 4'd1);
    pop();
    check_state("pop3", 31'h0, 1'b1, 3'd0, 4'd0);

    // Overflow: 10 pushes into 8 entries
    do_reset();
    for (int k = 1; k <= 10; k++) push(31'(k));
    check_state("ovf", 31'd10, 1'b0, 3'd2, 4'd8);
    for (int k = 0; k < 8; k++) begin
      check_eq("ovf.popval", {1'b0, ret_target}, 32'(10 - k));
      pop();
    end
    // entry[2] still holds 10 after the pointer wraps back to 2
    check_state("ovf.drained", 31'd10, 1'b1, 3'd2, 4'd0);
    pop();
    // entry[1] holds 9 (push 9 landed at index 1)
    check_state("ovf.underflow", 31'd9, 1'b1, 3'd1, 4'd0);

    // Simultaneous push+pop
    do_reset();
    push(31'h1000); push(31'h2000);
    check_state("pp.pre", 31'h2000, 1'b0, 3'd2, 4'd2);
    op(1'b1, 1'b1, 31'h4444, 1'b0, 3'd0, 4'd0);
    check_state("pp", 31'h4444, 1'b0, 3'd2, 4'd2);
    pop();
    check_state("pp.below", 31'h1000, 1'b0, 3'd1, 4'd1);
    do_reset();
    op(1'b1, 1'b1, 31'h5555, 1'b0, 3'd0, 4'd0);
    check_state("pp.empty", 31'h5555, 1'b0, 3'd0, 4'd1);

    // Restore with a simultaneous push that must be ignored
    do_reset();
    push(31'h111); push(31'h222);
    check_state("rs.save", 31'h222, 1'b0, 3'd2, 4'd2);
    push(31'h333); push(31'h444); push(31'h555);
    check_state("rs.more", 31'h555, 1'b0, 3'd5, 4'd5);
    op(1'b1, 1'b0, 31'h666, 1'b1, 3'd2, 4'd2);
    check_state("rs", 31'h222, 1'b0, 3'd2, 4'd2);
    // Restore to full then a pop wins only when restore is low
    op(1'b0, 1'b1, 31'h0, 1'b1, 3'd5, 4'd8);
    check_state("rs.full", 31'h555, 1'b0, 3'd5, 4'd8);
    push(31'h777);
    check_state("rs.fullpush", 31'h777, 1'b0, 3'd6, 4'd8);

    // Asynchronous reset mid-operation
    do_reset();
    for (int k = 1; k <= 5; k++) push(31'(k * 16));
    check_state("ar.pre", 31'd80, 1'b0, 3'd5, 4'd5);
    #2 RST = 1'b1;
    #1;
    check_state("ar.now", 31'd0, 1'b1, 3'd0, 4'd0);
    push_valid = 1'b1; push_target = 31'h9999;
    @(posedge CLK); #1;
    check_state("ar.hold", 31'd0, 1'b1, 3'd0, 4'd0);
    push_valid = 1'b0;
    RST = 1'b0;
    push(31'hABC);
    check_state("ar.after", 31'hABC, 1'b0, 3'd1, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
